// File: rtl/game_pkg.sv
// Shared game constants and types used by the sprite loader and the draw blocks.
// Contents: background colour, sprite frame sync marker, pixel width,
// and the sprite-loader FSM state enum.
package game_pkg;

    localparam int unsigned PIX_W = 12;

    // Background colour returned for any read outside the sprite.
    localparam logic [PIX_W-1:0] BG_COLOR = 12'h5C7;

    // First byte of every sprite frame on the UART stream.
    localparam logic [7:0] SPRITE_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        SPR_IDLE,
        SPR_HI,
        SPR_LO,
        SPR_CHK,
        SPR_FIN
    } sprite_ld_state_t;

endpackage

// File: rtl/sprite_dp_ram.sv
// Simple dual-port sprite RAM: one write port, one registered read-first read port.
// Ports:
//   clk, rst            clock; synchronous active-high reset (read register only)
//   we, wr_addr, wr_data  write port; out-of-range writes are dropped
//   rd_addr, rd_data      read port, 1-cycle latency; out-of-range reads return FILL
// Memory contents are not reset.
module sprite_dp_ram
    import game_pkg::*;
#(
    parameter int unsigned      DEPTH  = 3072,
    parameter int unsigned      WIDTH  = PIX_W,
    parameter int unsigned      ADDR_W = 20,
    parameter logic [WIDTH-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_in_range_c;
    logic             rd_in_range_c;

    always_comb begin
        wr_in_range_c = (wr_addr < ADDR_W'(DEPTH));
        rd_in_range_c = (rd_addr < ADDR_W'(DEPTH));
    end

    // Write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we && wr_in_range_c) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Read port; non-blocking read of mem gives the pre-write value on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= FILL;
        end else if (rd_in_range_c) begin
            rd_data <= mem[rd_addr[IDX_W-1:0]];
        end else begin
            rd_data <= FILL;
        end
    end

endmodule

// File: rtl/sprite_ram_loader.sv
// Loads a sprite from a UART byte stream into sprite RAM and serves the draw
// block's read port.
// Frame: SYNC_BYTE, then per pixel a HI byte (0x0R) and a LO byte (0xGB),
// row-major, SPRITE_W*SPRITE_H pixels.
// Optional: define SPRITE_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
// Ports:
//   clk, rst              clock; synchronous active-high reset (RAM contents kept)
//   rx_data, rx_valid     byte stream from UART RX
//   rd_address, rd_data   draw-block read port, 1-cycle latency, BG colour off-sprite
//   loading               frame in progress
//   done                  one-cycle pulse: full frame stored
//   error                 one-cycle pulse: frame aborted (bad HI byte, timeout, checksum)
module sprite_ram_loader
    import game_pkg::*;
#(
    parameter int unsigned SPRITE_W       = 48,
    parameter int unsigned SPRITE_H       = 64,
    parameter int unsigned ADDR_W         = 20,
    parameter logic [7:0]  SYNC_BYTE      = SPRITE_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [ADDR_W-1:0] rd_address,
    output logic [PIX_W-1:0]  rd_data,
    output logic              loading,
    output logic              done,
    output logic              error
);

    localparam int unsigned NPIX = SPRITE_W * SPRITE_H;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    sprite_ld_state_t  state;
    logic [ADDR_W-1:0] pix_cnt;
    logic [3:0]        hi_nib;
    logic [TO_W-1:0]   to_cnt;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q;
`endif

    logic              we_c;
    logic              last_pix_c;
    logic              timeout_c;

    always_comb begin
        we_c       = (state == SPR_LO) && rx_valid;
        last_pix_c = (pix_cnt == ADDR_W'(NPIX - 1));
        timeout_c  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    end

    // Frame parser; done/error/loading are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SPR_IDLE;
            pix_cnt <= '0;
            hi_nib  <= '0;
            to_cnt  <= '0;
            loading <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                SPR_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state   <= SPR_HI;
                        pix_cnt <= '0;
                        to_cnt  <= '0;
                        loading <= 1'b1;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        xor_q   <= '0;
`endif
                    end
                end
                SPR_HI, SPR_LO, SPR_CHK: begin
                    if (!rx_valid) begin
                        // Idle gap inside a frame: abort once the budget is used up.
                        if (timeout_c) begin
                            error   <= 1'b1;
                            loading <= 1'b0;
                            state   <= SPR_IDLE;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end else begin
                        to_cnt <= '0;
                        if (state == SPR_HI) begin
                            if (rx_data[7:4] != 4'h0) begin
                                error   <= 1'b1;
                                loading <= 1'b0;
                                state   <= SPR_IDLE;
                            end else begin
                                hi_nib <= rx_data[3:0];
                                state  <= SPR_LO;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                                xor_q  <= xor_q ^ rx_data;
`endif
                            end
                        end else if (state == SPR_LO) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                            xor_q <= xor_q ^ rx_data;
`endif
                            if (last_pix_c) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                                state   <= SPR_CHK;
`else
                                state   <= SPR_FIN;
                                done    <= 1'b1;
                                loading <= 1'b0;
`endif
                            end else begin
                                pix_cnt <= pix_cnt + ADDR_W'(1);
                                state   <= SPR_HI;
                            end
                        end else begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                            if (rx_data == xor_q) begin
                                state <= SPR_FIN;
                                done  <= 1'b1;
                            end else begin
                                state <= SPR_IDLE;
                                error <= 1'b1;
                            end
                            loading <= 1'b0;
`else
                            state   <= SPR_IDLE;
                            loading <= 1'b0;
`endif
                        end
                    end
                end
                SPR_FIN: begin
                    // One-cycle state; bytes arriving here are dropped.
                    state <= SPR_IDLE;
                end
                default: begin
                    state   <= SPR_IDLE;
                    loading <= 1'b0;
                end
            endcase
        end
    end

    sprite_dp_ram #(
        .DEPTH  (NPIX),
        .WIDTH  (PIX_W),
        .ADDR_W (ADDR_W),
        .FILL   (BG_COLOR)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we_c),
        .wr_addr (pix_cnt),
        .wr_data ({hi_nib, rx_data}),
        .rd_addr (rd_address),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Self-checking bench for sprite_ram_loader on an 4x2 sprite with a 16-cycle timeout.
module tb_sprite_ram_loader;
    import game_pkg::*;

    localparam int unsigned SW   = 4;
    localparam int unsigned SH   = 2;
    localparam int unsigned NPIX = SW * SH;
    localparam int unsigned TO   = 16;
    localparam int unsigned AW   = 20;

    typedef logic [7:0] byteq_t [$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] rd_address = '0;
    logic [11:0]   rd_data;
    logic          loading;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    sprite_ram_loader #(
        .SPRITE_W       (SW),
        .SPRITE_H       (SH),
        .ADDR_W         (AW),
        .SYNC_BYTE      (SPRITE_SYNC_BYTE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rd_address (rd_address),
        .rd_data    (rd_data),
        .loading    (loading),
        .done       (done),
        .error      (error)
    );

    int compared   = 0;
    int mismatched = 0;
    int done_seen  = 0;
    int err_seen   = 0;
    int both_seen  = 0;

    // Expected sprite RAM contents.
    logic [11:0] model [NPIX];

    // Pulse tallies, sampled just after each falling edge.
    always @(negedge clk) begin
        #1;
        if (done === 1'b1) done_seen++;
        if (error === 1'b1) err_seen++;
        if (done === 1'b1 && error === 1'b1) both_seen++;
    end

    // Pixel bytes of one frame (without the sync byte), plus checksum when enabled.
    function automatic byteq_t frame_bytes(input logic [11:0] px [NPIX]);
        byteq_t     q;
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < int'(NPIX); i++) begin
            q.push_back({4'h0, px[i][11:8]});
            q.push_back(px[i][7:0]);
            x = x ^ {4'h0, px[i][11:8]} ^ px[i][7:0];
        end
`ifdef SPRITE_LOADER_CHECKSUM_EN
        q.push_back(x);
`endif
        return q;
    endfunction

    task automatic rand_pixels(output logic [11:0] px [NPIX]);
        for (int i = 0; i < int'(NPIX); i++) px[i] = 12'($urandom);
    endtask

    // Called at a falling edge; returns at the falling edge right after the last byte's clock.
    task automatic send_bytes(input byteq_t q, input int min_gap, input int max_gap);
        for (int i = 0; i < q.size(); i++) begin
            rx_data  = q[i];
            rx_valid = 1'b1;
            @(negedge clk);
            if (i != q.size() - 1) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(max_gap, min_gap)) @(negedge clk);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        if (rd_data !== BG_COLOR) begin $display("FAIL reset_rd_data: got %h want %h", rd_data, BG_COLOR); mismatched++; end
        compared++;
        if ({loading, done, error} !== 3'b000) begin $display("FAIL reset_flags: got %b want 000", {loading, done, error}); mismatched++; end
        compared++;
        rst = 1'b0;
        @(negedge clk);
        if (loading !== 1'b0) begin $display("FAIL post_reset_loading: got %b want 0", loading); mismatched++; end
        compared++;
    endtask

    task automatic test_full_frame(input int min_gap, input int max_gap, input bit with_junk);
        logic [11:0] px [NPIX];
        byteq_t      q;
        byteq_t      s;
        int          d0;
        int          e0;
        rand_pixels(px);
        px[0] = 12'h00F;
        px[1] = 12'h123;
        px[2] = 12'h0A5;   // sync value as LO data must not restart the frame
        q  = frame_bytes(px);
        d0 = done_seen;
        e0 = err_seen;
        if (with_junk) begin
            s.push_back(8'h11);
            s.push_back(8'h22);
            s.push_back(8'h03);
            send_bytes(s, min_gap, max_gap);
            if (loading !== 1'b0) begin $display("FAIL junk_ignored: loading %b want 0", loading); mismatched++; end
            compared++;
            s.delete();
        end
        s.push_back(SPRITE_SYNC_BYTE);
        send_bytes(s, 0, 0);
        if (loading !== 1'b1) begin $display("FAIL sync_loading: got %b want 1", loading); mismatched++; end
        compared++;
        if (min_gap > 0) repeat (min_gap) @(negedge clk);
        send_bytes(q, min_gap, max_gap);
        if ({done, error} !== 2'b10) begin $display("FAIL frame_done: done/error %b want 10", {done, error}); mismatched++; end
        compared++;
        @(negedge clk);
        if ({done, loading} !== 2'b00) begin $display("FAIL frame_after: done/loading %b want 00", {done, loading}); mismatched++; end
        compared++;
        @(negedge clk);
        if (done_seen - d0 != 1 || err_seen != e0) begin
            $display("FAIL frame_pulses: done %0d err %0d want 1 0", done_seen - d0, err_seen - e0); mismatched++;
        end
        compared++;
        for (int i = 0; i < int'(NPIX); i++) model[i] = px[i];
    endtask

    // Sweeps one new address per clock, so any extra latency shows up as wrong data.
    task automatic test_read_port;
        logic [AW-1:0] a;
        logic [11:0]   exp;
        for (int i = 0; i < int'(NPIX) + 2; i++) begin
            if (i < int'(NPIX)) begin
                a = AW'(i); exp = model[i];
            end else if (i == int'(NPIX)) begin
                a = AW'(NPIX); exp = BG_COLOR;
            end else begin
                a = AW'($urandom_range((1 << AW) - 1, NPIX)); exp = BG_COLOR;
            end
            rd_address = a;
            @(negedge clk);
            if (rd_data !== exp) begin $display("FAIL read_addr_%0h: got %h want %h", a, rd_data, exp); mismatched++; end
            compared++;
        end
    endtask

    task automatic test_bad_hi;
        logic [11:0] p;
        byteq_t      q;
        p = 12'($urandom);
        q.push_back(SPRITE_SYNC_BYTE);
        q.push_back({4'h0, p[11:8]});
        q.push_back(p[7:0]);
        q.push_back(8'h1F);
        send_bytes(q, 0, 2);
        if ({error, done, loading} !== 3'b100) begin
            $display("FAIL bad_hi: error/done/loading %b want 100", {error, done, loading}); mismatched++;
        end
        compared++;
        @(negedge clk);
        if (error !== 1'b0) begin $display("FAIL bad_hi_pulse_width: error %b want 0", error); mismatched++; end
        compared++;
        model[0] = p;
    endtask

    task automatic test_timeout;
        logic [11:0] p;
        byteq_t      q;
        int          n;
        p = 12'($urandom);
        q.push_back(SPRITE_SYNC_BYTE);
        q.push_back({4'h0, p[11:8]});
        q.push_back(p[7:0]);
        send_bytes(q, 0, 0);
        model[0] = p;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (error === 1'b1) begin n = k; break; end
        end
        if (n != int'(TO)) begin $display("FAIL timeout_cycle: error after %0d idle cycles want %0d", n, TO); mismatched++; end
        compared++;
        if (loading !== 1'b0) begin $display("FAIL timeout_loading: got %b want 0", loading); mismatched++; end
        compared++;
    endtask

    task automatic test_collision;
        logic [11:0] px [NPIX];
        logic [11:0] old;
        byteq_t      q;
        byteq_t      pre;
        byteq_t      post;
        rand_pixels(px);
        old = model[5];
        if (px[5] == old) px[5] = ~old;
        q = frame_bytes(px);
        pre.push_back(SPRITE_SYNC_BYTE);
        for (int i = 0; i < 11; i++) pre.push_back(q[i]);       // pixels 0..4 and HI of pixel 5
        for (int i = 12; i < q.size(); i++) post.push_back(q[i]);
        send_bytes(pre, 0, 2);
        rd_address = AW'(5);
        rx_data    = q[11];
        rx_valid   = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        if (rd_data !== old) begin $display("FAIL collision_old: got %h want %h", rd_data, old); mismatched++; end
        compared++;
        @(negedge clk);
        if (rd_data !== px[5]) begin $display("FAIL collision_new: got %h want %h", rd_data, px[5]); mismatched++; end
        compared++;
        send_bytes(post, 0, 2);
        if (done !== 1'b1) begin $display("FAIL collision_done: got %b want 1", done); mismatched++; end
        compared++;
        for (int i = 0; i < int'(NPIX); i++) model[i] = px[i];
    endtask

    task automatic test_reset_mid_frame;
        logic [11:0] px [NPIX];
        byteq_t      q;
        byteq_t      s;
        int          d0;
        int          e0;
        rand_pixels(px);
        q  = frame_bytes(px);
        d0 = done_seen;
        e0 = err_seen;
        s.push_back(SPRITE_SYNC_BYTE);
        for (int i = 0; i < 5; i++) s.push_back(q[i]);          // two pixels and a HI byte
        send_bytes(s, 0, 1);
        model[0] = px[0];
        model[1] = px[1];
        rst = 1'b1;
        @(negedge clk);
        if ({loading, done, error} !== 3'b000) begin
            $display("FAIL midreset_flags: got %b want 000", {loading, done, error}); mismatched++;
        end
        compared++;
        rst = 1'b0;
        s.delete();
        s.push_back(q[5]);                                       // would have been a LO byte
        send_bytes(s, 0, 0);
        if (loading !== 1'b0) begin $display("FAIL midreset_idle: loading %b want 0", loading); mismatched++; end
        compared++;
        repeat (2) @(negedge clk);
        if (done_seen != d0 || err_seen != e0) begin
            $display("FAIL midreset_pulses: done %0d err %0d want 0 0", done_seen - d0, err_seen - e0); mismatched++;
        end
        compared++;
    endtask

`ifdef SPRITE_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum;
        logic [11:0] px [NPIX];
        byteq_t      q;
        byteq_t      s;
        rand_pixels(px);
        q = frame_bytes(px);
        q[q.size() - 1] = q[q.size() - 1] ^ 8'h5A;
        s.push_back(SPRITE_SYNC_BYTE);
        send_bytes(s, 0, 0);
        send_bytes(q, 0, 2);
        if ({error, done} !== 2'b10) begin $display("FAIL bad_checksum: error/done %b want 10", {error, done}); mismatched++; end
        compared++;
        for (int i = 0; i < int'(NPIX); i++) model[i] = px[i];
    endtask
`endif

    initial begin
        test_reset;
        test_full_frame(1, 3, 1'b0);
        test_read_port;
        test_full_frame(0, 0, 1'b1);
        test_read_port;
        test_bad_hi;
        test_read_port;
        test_full_frame(0, 2, 1'b0);
        test_read_port;
        test_timeout;
        test_read_port;
        test_full_frame(15, 15, 1'b0);
        test_collision;
        test_read_port;
        test_reset_mid_frame;
        test_read_port;
`ifdef SPRITE_LOADER_CHECKSUM_EN
        test_bad_checksum;
        test_read_port;
`endif
        repeat (2) @(negedge clk);
        if (both_seen != 0) begin $display("FAIL done_error_overlap: got %0d cycles want 0", both_seen); mismatched++; end
        compared++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
